trace_dump_reader: RTL and testbench

- Read-side companion to the MPSoC trace buffer. Drains captured 32-bit trace words through the buffer's rd/dout port.
- Serialises the words into a framed byte stream with a valid/ready handshake, for the JTAG/UART debug bridge.
- Sits at SoC top level beside the trace buffer and shares its clock.
- One dump request produces one complete frame.

---
 rtl/trace_dump_reader.sv | 154 +++++++++++++++
 tb/tb_trace_dump_reader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_dump_reader.sv
// Drains trace words from the trace buffer into a framed, checksummed byte stream.
// 0xA5 is valid the cycle after dump_req is sampled; any byte is held while out_ready is low.
module trace_dump_reader #(
  parameter int Fpay      = 32,
  parameter int MAX_WORDS = 512,
  parameter int CNTw      = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            dump_req,
  output logic            busy,
  output logic            dump_done,
  input  logic            tb_empty,
  output logic            tb_rd,
  input  logic [Fpay-1:0] tb_dout,
  output logic [7:0]      out_data,
  output logic            out_valid,
  input  logic            out_ready
);

  localparam int BYTES = Fpay / 8;
  localparam int IDXW  = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [7:0] SOF_BYTE = 8'hA5;
  localparam logic [7:0] TAG_BYTE = 8'hD0;
  localparam logic [7:0] EOF_BYTE = 8'hE0;

  typedef enum logic [3:0] {
    IDLE, SOF, CHECK, LOAD, TAG, DATA, END_E0, END_H, END_L, CSUM
  } state_t;

  state_t          state;
  logic [CNTw-1:0] wcnt;
  logic [IDXW-1:0] idx;
  logic [7:0]      csum;
  logic [Fpay-1:0] shreg;

  logic            xfer;
  logic            room;
  logic            last_byte;
  logic [15:0]     cnt16;
  logic [Fpay-1:0] shreg_nxt;

  assign xfer      = out_valid && out_ready;
  assign room      = !tb_empty && (wcnt != CNTw'(MAX_WORDS));
  assign last_byte = (idx == IDXW'(BYTES - 1));
  assign cnt16     = 16'(wcnt);
  assign shreg_nxt = shreg << 8;

  // The read strobe must follow tb_empty in the same CHECK cycle, so it is decoded from state.
  assign tb_rd = (state == CHECK) && room;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      dump_done <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      wcnt      <= '0;
      idx       <= '0;
      csum      <= 8'h00;
      shreg     <= '0;
    end else begin
      dump_done <= 1'b0;
      case (state)
        IDLE: begin
          if (dump_req) begin
            state     <= SOF;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            out_data  <= SOF_BYTE;
            wcnt      <= '0;
            csum      <= 8'h00;
          end
        end
        SOF: begin
          if (xfer) begin
            state     <= CHECK;
            out_valid <= 1'b0;
          end
        end
        CHECK: begin
          if (room) begin
            state <= LOAD;
          end else begin
            state     <= END_E0;
            out_valid <= 1'b1;
            out_data  <= EOF_BYTE;
          end
        end
        LOAD: begin
          shreg     <= tb_dout;
          state     <= TAG;
          out_valid <= 1'b1;
          out_data  <= TAG_BYTE;
        end
        TAG: begin
          if (xfer) begin
            csum     <= csum ^ out_data;
            idx      <= '0;
            state    <= DATA;
            out_data <= shreg[Fpay-1 -: 8];
          end
        end
        DATA: begin
          if (xfer) begin
            csum  <= csum ^ out_data;
            shreg <= shreg_nxt;
            if (last_byte) begin
              wcnt      <= wcnt + CNTw'(1);
              state     <= CHECK;
              out_valid <= 1'b0;
            end else begin
              idx      <= idx + IDXW'(1);
              out_data <= shreg_nxt[Fpay-1 -: 8];
            end
          end
        end
        END_E0: begin
          if (xfer) begin
            csum     <= csum ^ out_data;
            out_data <= cnt16[15:8];
            state    <= END_H;
          end
        end
        END_H: begin
          if (xfer) begin
            csum     <= csum ^ out_data;
            out_data <= cnt16[7:0];
            state    <= END_L;
          end
        end
        END_L: begin
          if (xfer) begin
            csum     <= csum ^ out_data;
            out_data <= csum ^ out_data;
            state    <= CSUM;
          end
        end
        CSUM: begin
          if (xfer) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            dump_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trace_dump_reader.sv
// Random frames against a byte-level frame model, with a small trace-buffer model behind the DUT.
module tb_trace_dump_reader;

  localparam int MAXW = 4;

  logic        clk       = 1'b0;
  logic        reset     = 1'b0;
  logic        dump_req  = 1'b0;
  logic        out_ready = 1'b0;
  logic        tb_empty;
  logic [31:0] tb_dout   = '0;
  logic        busy;
  logic        dump_done;
  logic        tb_rd;
  logic        out_valid;
  logic [7:0]  out_data;

  trace_dump_reader #(.Fpay(32), .MAX_WORDS(MAXW), .CNTw(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .dump_req  (dump_req),
    .busy      (busy),
    .dump_done (dump_done),
    .tb_empty  (tb_empty),
    .tb_rd     (tb_rd),
    .tb_dout   (tb_dout),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Trace buffer: read data appears one cycle after tb_rd.
  logic [31:0] buf_q[$];
  int          buf_n    = 0;
  logic        push_vld = 1'b0;
  logic [31:0] push_dat = '0;
  int          rd_cnt   = 0;
  int          rd_empty = 0;

  assign tb_empty = (buf_n == 0);

  always @(posedge clk) begin
    if (tb_rd) begin
      rd_cnt++;
      if (buf_q.size() == 0) rd_empty++;
      else tb_dout <= buf_q.pop_front();
    end
    if (push_vld) buf_q.push_back(push_dat);
    buf_n <= buf_q.size();
  end

  // Downstream readiness: 0 always ready, 1 toggling, 2 random.
  int rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = ($urandom_range(0, 1) == 1);
    endcase
  end

  // Stream monitor: a byte seen valid&&ready here transfers on the next rising edge.
  logic [7:0] got_q[$];
  int         done_cnt   = 0;
  int         done_bad   = 0;
  int         stall_bad  = 0;
  logic       prev_stall = 1'b0;
  logic       prev_xfer  = 1'b0;
  logic [7:0] prev_dat   = '0;

  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 1'b0;
      prev_xfer  = 1'b0;
    end else begin
      if (prev_stall && (!out_valid || out_data !== prev_dat)) stall_bad++;
      if (dump_done) begin
        done_cnt++;
        if (!prev_xfer || busy) done_bad++;
      end
      prev_stall = out_valid && !out_ready;
      prev_xfer  = out_valid && out_ready;
      prev_dat   = out_data;
      if (out_valid && out_ready) got_q.push_back(out_data);
    end
  end

  logic [31:0] model_q[$];

  task automatic push_word(input logic [31:0] w);
    push_vld = 1'b1;
    push_dat = w;
    model_q.push_back(w);
    @(posedge clk); #1;
    push_vld = 1'b0;
  endtask

  task automatic pulse_req();
    dump_req = 1'b1;
    @(posedge clk); #1;
    dump_req = 1'b0;
  endtask

  task automatic run_frame(input bit extra_req);
    logic [7:0]  exp_q[$];
    logic [7:0]  cs;
    logic [31:0] w;
    int n, base, rd0, dn0, k;
    n = (model_q.size() < MAXW) ? model_q.size() : MAXW;
    exp_q.push_back(8'hA5);
    for (int i = 0; i < n; i++) begin
      w = model_q.pop_front();
      exp_q.push_back(8'hD0);
      for (int b = 3; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
    end
    exp_q.push_back(8'hE0);
    exp_q.push_back(8'(n >> 8));
    exp_q.push_back(8'(n));
    cs = 8'h00;
    for (int i = 1; i < exp_q.size(); i++) cs = cs ^ exp_q[i];
    exp_q.push_back(cs);

    base = got_q.size();
    rd0  = rd_cnt;
    dn0  = done_cnt;
    @(posedge clk); #1;
    pulse_req();
    chk("sof_valid", {31'b0, out_valid}, 32'd1);
    chk("sof_data", {24'b0, out_data}, 32'hA5);
    chk("sof_busy", {31'b0, busy}, 32'd1);
    if (extra_req) begin
      repeat ($urandom_range(0, 15)) begin
        @(posedge clk); #1;
      end
      if (busy) pulse_req();
    end
    k = 0;
    while (done_cnt == dn0 && k < 3000) begin
      @(posedge clk); #1;
      k++;
    end
    chk("frame_done", done_cnt - dn0, 32'd1);
    repeat (12) @(posedge clk);
    #1;
    chk("done_pulses", done_cnt - dn0, 32'd1);
    chk("rd_pulses", rd_cnt - rd0, n);
    chk("byte_count", got_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < got_q.size())
        chk($sformatf("byte%0d", i), {24'b0, got_q[base+i]}, {24'b0, exp_q[i]});
    chk("buf_left", buf_q.size(), model_q.size());
    chk("idle_busy", {31'b0, busy}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_busy"}, {31'b0, busy}, 32'd0);
    chk({pfx, "_done"}, {31'b0, dump_done}, 32'd0);
    chk({pfx, "_rd"}, {31'b0, tb_rd}, 32'd0);
    chk({pfx, "_valid"}, {31'b0, out_valid}, 32'd0);
    chk({pfx, "_data"}, {24'b0, out_data}, 32'd0);
  endtask

  task automatic reset_mid_frame();
    int base, rd0, k;
    rdy_mode = 0;
    for (int i = 0; i < 3; i++) push_word($urandom);
    base = got_q.size();
    rd0  = rd_cnt;
    pulse_req();
    // Byte 7 is the first data byte of the second word.
    k = 0;
    while (got_q.size() - base < 8 && k < 200) begin
      @(negedge clk); #2;
      k++;
    end
    chk("reach_word2", got_q.size() - base, 32'd8);
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    chk("midrst_reads", rd_cnt - rd0, 32'd2);
    void'(model_q.pop_front());
    void'(model_q.pop_front());
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("midrst_hold");
    reset = 1'b1;
    @(posedge clk); #1;
    run_frame(1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b1;
    @(posedge clk); #1;

    rdy_mode = 0;
    run_frame(1'b0);
    chk("empty_csum", {24'b0, got_q[got_q.size()-1]}, 32'hE0);

    push_word(32'h12345678);
    run_frame(1'b0);
    chk("one_word_csum", {24'b0, got_q[got_q.size()-1]}, 32'h39);

    rdy_mode = 1;
    push_word(32'h12345678);
    run_frame(1'b0);
    chk("toggle_csum", {24'b0, got_q[got_q.size()-1]}, 32'h39);

    rdy_mode = 0;
    for (int i = 0; i < 6; i++) push_word($urandom);
    run_frame(1'b0);
    chk("sat_left", buf_q.size(), 32'd2);

    reset_mid_frame();

    rdy_mode = 2;
    push_word($urandom);
    push_word($urandom);
    run_frame(1'b1);

    for (int f = 0; f < 20; f++) begin
      rdy_mode = $urandom_range(0, 2);
      repeat ($urandom_range(0, 6)) push_word($urandom);
      run_frame($urandom_range(0, 1) == 1);
    end

    chk("stall_hold", stall_bad, 32'd0);
    chk("done_timing", done_bad, 32'd0);
    chk("rd_on_empty", rd_empty, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
